// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder control stage:
// phase encodings, direction and FSM state types, and the
// forward-neighbour helper for the Gray-code phase cycle.
package qdec_pkg;

    // Phase P = {A, B}; forward cycle is 00 -> 01 -> 11 -> 10 -> 00
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_e;

    // Forward neighbour of a phase in the Gray-code cycle
    function automatic logic [1:0] next_fwd(input logic [1:0] phase);
        logic [1:0] nxt;
        case (phase)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            PH_10:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage : qdec_pkg

// File: rtl/qdec_filter.sv
// Synchroniser chain followed by a consecutive-sample glitch filter.
// The filtered level flips only after the synchronised level has
// disagreed with it for FILT_LEN consecutive clock edges; any agreeing
// sample restarts the count. 'busy' reports that a change is pending
// anywhere in the chain or the counter, i.e. the filter is not settled.
module qdec_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt,
    output logic busy
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;
    logic                   filt_q, filt_d;
    logic                   synced_s;

    assign synced_s = sync_q[SYNC_STAGES-1];

    // Next-state logic: shift the synchroniser and run the agreement counter
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (synced_s != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = synced_s;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
    assign busy = (cnt_q != {CNT_W{1'b0}}) || (sync_q != {SYNC_STAGES{filt_q}});

endmodule : qdec_filter

// File: rtl/quad_decoder_ctrl.sv
// Quadrature encoder front end for the 3-bit up/down counter.
// Filters A/B/index, decodes Gray-code steps into one-cycle count
// pulses with a held direction, turns index rising edges into a load
// of idx_value, and flags illegal (two-bit) phase jumps in a sticky err.
// Optional macro QDEC_ERR_CNT_EN adds a saturating illegal-jump counter
// on output err_cnt.
module quad_decoder_ctrl
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int DATA_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enc_a,
    input  logic              enc_b,
    input  logic              enc_idx,
    input  logic              enable,
    input  logic [DATA_W-1:0] idx_value,
    input  logic              err_clr,
    output logic              counter_on,
    output logic              count_up,
    output logic              load,
    output logic [DATA_W-1:0] data_out,
    output logic              err
`ifdef QDEC_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    // INIT first lets the synchroniser chains fill with real samples
    // (they were zeroed by reset), so a stale all-zero chain is never
    // mistaken for a settled input when reset drops while A/B are high.
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);

    logic a_filt_s, b_filt_s, idx_filt_s;
    logic a_busy_s, b_busy_s, idx_busy_unused_s;
    logic [1:0] phase_s;
    logic step_s, illegal_s, idx_rise_s;

    state_e            state_q,      state_d;
    logic [WARM_W-1:0] warm_q,       warm_d;
    logic [1:0]        prev_phase_q, prev_phase_d;
    logic              idx_prev_q,   idx_prev_d;
    logic              counter_on_q, counter_on_d;
    logic              count_up_q,   count_up_d;
    logic              load_q,       load_d;
    logic [DATA_W-1:0] data_out_q,   data_out_d;
    logic              err_q,        err_d;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .raw   (enc_a),
        .filt  (a_filt_s),
        .busy  (a_busy_s)
    );

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .raw   (enc_b),
        .filt  (b_filt_s),
        .busy  (b_busy_s)
    );

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_idx (
        .clk   (clk),
        .reset (reset),
        .raw   (enc_idx),
        .filt  (idx_filt_s),
        .busy  (idx_busy_unused_s)
    );

    assign phase_s    = {a_filt_s, b_filt_s};
    assign idx_rise_s = idx_filt_s & ~idx_prev_q;

    // FSM next state, step decode, index load and sticky error
    always_comb begin
        state_d      = state_q;
        warm_d       = warm_q;
        prev_phase_d = prev_phase_q;
        count_up_d   = count_up_q;
        data_out_d   = data_out_q;
        err_d        = err_q;
        counter_on_d = 1'b0;
        load_d       = 1'b0;
        step_s       = 1'b0;
        illegal_s    = 1'b0;
        idx_prev_d   = idx_filt_s;

        case (state_q)
            INIT: begin
                if (warm_q != WARM_DONE) begin
                    warm_d = warm_q + WARM_W'(1);
                end else if (!a_busy_s && !b_busy_s) begin
                    // Adopt the settled phase silently: no count after reset
                    prev_phase_d = phase_s;
                    state_d      = TRACK;
                end else begin
                    state_d = INIT;
                end
            end
            TRACK: begin
                if (phase_s != prev_phase_q) begin
                    prev_phase_d = phase_s;
                    if (phase_s == next_fwd(prev_phase_q)) begin
                        step_s     = 1'b1;
                        count_up_d = DIR_UP;
                    end else if (prev_phase_q == next_fwd(phase_s)) begin
                        step_s     = 1'b1;
                        count_up_d = DIR_DOWN;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    prev_phase_d = prev_phase_q;
                end
            end
            default: begin
                state_d = INIT;
                warm_d  = {WARM_W{1'b0}};
            end
        endcase

        // Tracking continues while disabled; only the pulses are gated
        counter_on_d = step_s & enable;

        if (idx_rise_s && enable) begin
            load_d     = 1'b1;
            data_out_d = idx_value;
        end else begin
            load_d = 1'b0;
        end

        // A new illegal jump wins over a simultaneous clear
        if (illegal_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT;
            warm_q       <= {WARM_W{1'b0}};
            prev_phase_q <= PH_00;
            idx_prev_q   <= 1'b0;
            counter_on_q <= 1'b0;
            count_up_q   <= 1'b1;
            load_q       <= 1'b0;
            data_out_q   <= {DATA_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_q       <= warm_d;
            prev_phase_q <= prev_phase_d;
            idx_prev_q   <= idx_prev_d;
            counter_on_q <= counter_on_d;
            count_up_q   <= count_up_d;
            load_q       <= load_d;
            data_out_q   <= data_out_d;
            err_q        <= err_d;
        end
    end

    assign counter_on = counter_on_q;
    assign count_up   = count_up_q;
    assign load       = load_q;
    assign data_out   = data_out_q;
    assign err        = err_q;

`ifdef QDEC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating illegal-jump counter; an increment alongside a clear gives 1
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (illegal_s) begin
            if (err_clr) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'd255) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else if (err_clr) begin
            err_cnt_d = 8'd0;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule : quad_decoder_ctrl

// File: doc/quad_decoder_ctrl.md
Name: quad_decoder_ctrl

Overview:
Upstream control stage for the 3-bit up/down counter. It turns raw quadrature encoder inputs (A, B, index) into that counter's control inputs: load, count_up, counter_on and Data_in.
- Each input is synchronised and glitch-filtered.
- Gray-code phase steps decode to one-cycle count pulses with a direction.
- An index pulse produces a one-cycle load of a preset value.
- Illegal phase jumps are flagged.

Parameters:
SYNC_STAGES, 2, synchroniser flops per raw input (min 2)
FILT_LEN, 3, consecutive identical synchronised samples required before a filtered level changes (min 1)
DATA_W, 3, width of idx_value/data_out (matches the counter's Data_in)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enc_a  in  1  raw encoder phase A, asynchronous
enc_b  in  1  raw encoder phase B, asynchronous
enc_idx  in  1  raw encoder index, asynchronous
enable  in  1  1 = emit count/load pulses; 0 = track only
idx_value  in  DATA_W  value loaded on index
err_clr  in  1  clears err
counter_on  out  1  one-cycle count-enable pulse
count_up  out  1  direction of last valid step (1 = up)
load  out  1  one-cycle load pulse
data_out  out  DATA_W  load value, drives the counter's Data_in
err  out  1  sticky illegal-transition flag

Behaviour:
- Reset, sampled at a rising edge of clk, takes priority over everything:
  - counter_on=0, load=0, count_up=1, data_out=0, err=0.
  - All sync flops, filtered levels and filter counters = 0.
  - FSM = INIT.
- Filter, per input:
  - The filtered level changes only after the synchronised level differs from it for FILT_LEN consecutive edges.
  - Any agreeing sample in between restarts the count.
- Latency: a clean level change first sampled at edge N produces its pulse in the cycle after edge N+SYNC_STAGES+FILT_LEN.
- Phase encoding is P={A,B}. The forward cycle is 00->01->11->10->00.
- FSM INIT:
  - Waits until the A and B filter counters are both idle.
  - Then captures P as prev_phase without any output pulse, and moves to TRACK.
  - This prevents a spurious count after reset.
- FSM TRACK, when the filtered P differs from prev_phase:
  - Forward neighbour: counter_on=1, count_up=1.
  - Reverse neighbour: counter_on=1, count_up=0.
  - Both bits changed in the same cycle: no pulse, err=1, count_up unchanged.
  - In all three cases prev_phase is updated to P.
- counter_on is high for exactly one cycle per valid step. count_up is held between steps.
- Index: a rising edge of the filtered idx gives load=1 for one cycle, with data_out=idx_value registered in the same cycle. data_out holds until the next load.
- A step and an index in the same cycle: both load and counter_on are asserted. The counter's load priority discards the step; this is intended (index re-zeroes position).
- enable=0:
  - counter_on and load are forced to 0.
  - Filters, FSM, prev_phase, count_up and err keep updating, so no catch-up pulse occurs on re-enable.
- err:
  - err_clr=1 clears err.
  - If an illegal transition occurs in the same cycle as err_clr, err=1 (set wins).
- Reset asserted mid-stream: outputs are cleared on that edge, and the FSM returns to INIT once reset is released.

Optional Feature:
QDEC_ERR_CNT_EN
- Defined: adds output err_cnt[7:0].
  - Increments on each illegal transition and saturates at 255.
  - Cleared by reset and by err_clr. An increment in the same cycle as err_clr gives 1.
- Undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Package qdec_pkg holds:
  - Phase constants PH_00, PH_01, PH_11, PH_10.
  - A direction typedef (DIR_DOWN=0, DIR_UP=1).
  - FSM state typedef (INIT, TRACK).
  - A function next_fwd(phase) returning the forward neighbour.
- Sub-module qdec_filter (synchroniser plus FILT_LEN filter, parameters SYNC_STAGES and FILT_LEN) is instantiated three times: A, B, idx.

Test Plan:
- Reset, then hold A=B=0 for 20 cycles -> no counter_on, load, or err; count_up=1.
- Defaults, enable=1, drive 00->01->11->10->00 with each level held 8 cycles -> 4 counter_on pulses with count_up=1. The first pulse appears 6 cycles (SYNC_STAGES+FILT_LEN+1) after the first edge that samples A/B=01.
- Reverse sequence 00->10->11->01 -> 3 pulses with count_up=0. A 2-cycle glitch on A -> no pulse.
- A/B jump 00->11 -> err=1 with no pulse. err_clr pulse -> err=0. Illegal transition coincident with err_clr -> err stays 1 (err_cnt=1 when QDEC_ERR_CNT_EN is defined).
- idx_value=5 and an index pulse of 5 cycles -> a single load pulse with data_out=5. The same pulse with enable=0 -> no load.
- Reset asserted mid-sequence, then released while A/B=11 -> no pulse and no err. The next forward step 11->10 -> one up pulse.
